difftest_commit_stage: RTL and testbench

- Parametrised multi-channel retire-to-difftest staging block. It replaces single-instruction, per-cycle commit registering at the top level.
- Accepts up to NR_COMMIT retirements per cycle from a pipelined core.
- Compacts them, filters x0 writes, applies skip rules, counts cycles and instructions, detects the halt trap and an optional no-commit watchdog.
- Registered outputs drive DifftestInstrCommit (one instance per index), DifftestTrapEvent and the perf counters.

---
 rtl/difftest_commit_stage_if.sv | 43 ++++
 rtl/difftest_commit_stage.sv | 206 ++++++++++++++++++++
 tb/tb_difftest_commit_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/difftest_commit_stage_if.sv
// Bundle of retire-side inputs and difftest-side outputs for difftest_commit_stage.
// The master modport is the core/top level, the slave modport is the staging block.
interface difftest_commit_stage_if #(
  parameter int NR_COMMIT = 2,
  parameter int XLEN      = 64
);

  logic [NR_COMMIT-1:0]      in_valid;
  logic [NR_COMMIT*XLEN-1:0] in_pc;
  logic [NR_COMMIT*32-1:0]   in_inst;
  logic [NR_COMMIT-1:0]      in_wen;
  logic [NR_COMMIT*5-1:0]    in_wdest;
  logic [NR_COMMIT*XLEN-1:0] in_wdata;
  logic [NR_COMMIT-1:0]      in_skip;
  logic [XLEN-1:0]           in_a0;

  logic [NR_COMMIT-1:0]      cmt_valid;
  logic [NR_COMMIT*XLEN-1:0] cmt_pc;
  logic [NR_COMMIT*32-1:0]   cmt_inst;
  logic [NR_COMMIT-1:0]      cmt_skip;
  logic [NR_COMMIT-1:0]      cmt_wen;
  logic [NR_COMMIT*8-1:0]    cmt_wdest;
  logic [NR_COMMIT*XLEN-1:0] cmt_wdata;
  logic                      trap_valid;
  logic [7:0]                trap_code;
  logic [XLEN-1:0]           trap_pc;
  logic [63:0]               cycle_cnt;
  logic [63:0]               instr_cnt;
  logic                      halted;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0,
    input  cmt_valid, cmt_pc, cmt_inst, cmt_skip, cmt_wen, cmt_wdest, cmt_wdata,
    input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, halted
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0,
    output cmt_valid, cmt_pc, cmt_inst, cmt_skip, cmt_wen, cmt_wdest, cmt_wdata,
    output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, halted
  );

endinterface

// File: rtl/difftest_commit_stage.sv
// Multi-channel retire-to-difftest staging block.
// Compacts up to NR_COMMIT retirements per cycle into a prefix of output slots,
// filters x0 writes, marks skipped commits, counts cycles/instructions and
// detects the 0x6b halt trap. All outputs are registered (1-cycle latency).
// Optional no-commit watchdog is built when DIFFTEST_WATCHDOG_EN is defined.
module difftest_commit_stage #(
  parameter int          NR_COMMIT  = 2,
  parameter int          XLEN       = 64,
  parameter logic [63:0] PC_START   = 64'h8000_0000,
  parameter int          WD_TIMEOUT = 4096
) (
  input logic                    clock,
  input logic                    reset,
  difftest_commit_stage_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] PC_START_X = XLEN'(PC_START);

  state_t state_q, state_d;

  logic                      run;
  logic                      trap_found;
  int                        trap_idx;
  logic [NR_COMMIT-1:0]      survive;
  int                        slot_of [NR_COMMIT];
  logic [3:0]                commit_cnt;
  logic                      any_commit;
  logic [XLEN-1:0]           youngest_pc;
  logic [7:0]                trap_code_d;
  logic                      wd_fire;

  logic [NR_COMMIT-1:0]      valid_d, skip_d, wen_d;
  logic [NR_COMMIT*XLEN-1:0] pc_d, wdata_d;
  logic [NR_COMMIT*32-1:0]   inst_d;
  logic [NR_COMMIT*8-1:0]    wdest_d;

  logic [NR_COMMIT-1:0]      valid_q, skip_q, wen_q;
  logic [NR_COMMIT*XLEN-1:0] pc_q, wdata_q;
  logic [NR_COMMIT*32-1:0]   inst_q;
  logic [NR_COMMIT*8-1:0]    wdest_q;
  logic                      trap_valid_q;
  logic [7:0]                trap_code_q;
  logic [XLEN-1:0]           trap_pc_q;
  logic [XLEN-1:0]           last_pc_q;
  logic [63:0]               cycle_cnt_q;
  logic [63:0]               instr_cnt_q;

  // Only the low byte of a0 becomes an exit code.
  logic unused_a0_hi;
  assign unused_a0_hi = ^bus.in_a0[XLEN-1:8];

  assign run = (state_q == RUN);

  // Find the oldest trap, decide which channels survive and where each lands.
  always_comb begin
    trap_found  = 1'b0;
    trap_idx    = 0;
    survive     = '0;
    commit_cnt  = '0;
    youngest_pc = '0;
    trap_code_d = bus.in_a0[7:0];
    for (int i = 0; i < NR_COMMIT; i++) begin
      slot_of[i] = 0;
    end
    for (int i = 0; i < NR_COMMIT; i++) begin
      if (run && !trap_found && bus.in_valid[i] && (bus.in_inst[i*32 +: 7] == 7'h6b)) begin
        trap_found = 1'b1;
        trap_idx   = i;
      end
    end
    for (int i = 0; i < NR_COMMIT; i++) begin
      survive[i] = run && bus.in_valid[i] && (!trap_found || (i <= trap_idx));
      slot_of[i] = int'(commit_cnt);
      if (survive[i]) begin
        commit_cnt  = commit_cnt + 4'd1;
        youngest_pc = bus.in_pc[i*XLEN +: XLEN];
      end
      if (trap_found && (i < trap_idx) && bus.in_valid[i] && bus.in_wen[i] &&
          (bus.in_wdest[i*5 +: 5] == 5'd10)) begin
        trap_code_d = bus.in_wdata[i*XLEN +: 8];
      end
    end
    any_commit = (commit_cnt != 4'd0);
  end

  // Route each surviving channel into its compacted output slot; unused slots stay zero.
  always_comb begin
    valid_d = '0;
    skip_d  = '0;
    wen_d   = '0;
    pc_d    = '0;
    wdata_d = '0;
    inst_d  = '0;
    wdest_d = '0;
    for (int k = 0; k < NR_COMMIT; k++) begin
      for (int i = 0; i < NR_COMMIT; i++) begin
        if (survive[i] && (slot_of[i] == k)) begin
          valid_d[k]              = 1'b1;
          pc_d[k*XLEN +: XLEN]    = bus.in_pc[i*XLEN +: XLEN];
          inst_d[k*32 +: 32]      = bus.in_inst[i*32 +: 32];
          wdata_d[k*XLEN +: XLEN] = bus.in_wdata[i*XLEN +: XLEN];
          wdest_d[k*8 +: 8]       = {3'd0, bus.in_wdest[i*5 +: 5]};
          wen_d[k]                = bus.in_wen[i] && (bus.in_wdest[i*5 +: 5] != 5'd0);
          skip_d[k]               = bus.in_skip[i] || (bus.in_pc[i*XLEN +: XLEN] == PC_START_X);
        end
      end
    end
  end

`ifdef DIFFTEST_WATCHDOG_EN
  logic [31:0] wd_cnt_q;

  assign wd_fire = run && !any_commit && (wd_cnt_q == 32'(WD_TIMEOUT - 1));

  // Count consecutive RUN cycles without any surviving commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (run) begin
      wd_cnt_q <= any_commit ? 32'd0 : wd_cnt_q + 32'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Next-state: leave RUN on a real trap or a watchdog expiry; HALT is sticky.
  always_comb begin
    state_d = state_q;
    if (run && (trap_found || wd_fire)) begin
      state_d = HALT;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slots, counters, last committed PC and trap event registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      skip_q       <= '0;
      wen_q        <= '0;
      pc_q         <= '0;
      wdata_q      <= '0;
      inst_q       <= '0;
      wdest_q      <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      last_pc_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      skip_q  <= skip_d;
      wen_q   <= wen_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      inst_q  <= inst_d;
      wdest_q <= wdest_d;
      if (run) begin
        cycle_cnt_q <= cycle_cnt_q + 64'd1;
        instr_cnt_q <= instr_cnt_q + 64'(commit_cnt);
        if (any_commit) begin
          last_pc_q <= youngest_pc;
        end
        if (trap_found) begin
          trap_valid_q <= 1'b1;
          trap_code_q  <= trap_code_d;
          trap_pc_q    <= bus.in_pc[trap_idx*XLEN +: XLEN];
        end else if (wd_fire) begin
          trap_valid_q <= 1'b1;
          trap_code_q  <= 8'hFF;
          trap_pc_q    <= last_pc_q;
        end
      end
    end
  end

  assign bus.cmt_valid  = valid_q;
  assign bus.cmt_pc     = pc_q;
  assign bus.cmt_inst   = inst_q;
  assign bus.cmt_skip   = skip_q;
  assign bus.cmt_wen    = wen_q;
  assign bus.cmt_wdest  = wdest_q;
  assign bus.cmt_wdata  = wdata_q;
  assign bus.trap_valid = trap_valid_q;
  assign bus.trap_code  = trap_code_q;
  assign bus.trap_pc    = trap_pc_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.instr_cnt  = instr_cnt_q;
  assign bus.halted     = (state_q == HALT);

endmodule

// File: tb/tb_difftest_commit_stage.sv
// Self-checking bench for difftest_commit_stage (NR_COMMIT=2, XLEN=64, WD_TIMEOUT=8).
// A queue-based reference model predicts every registered output each cycle.
module tb_difftest_commit_stage;

  localparam int          NC         = 2;
  localparam int          XL         = 64;
  localparam logic [63:0] PC_START   = 64'h8000_0000;
  localparam int          WD_TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  difftest_commit_stage_if #(.NR_COMMIT(NC), .XLEN(XL)) bus ();

  difftest_commit_stage #(
    .NR_COMMIT (NC),
    .XLEN      (XL),
    .PC_START  (PC_START),
    .WD_TIMEOUT(WD_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // stimulus, one entry per channel
  logic        s_valid [NC];
  logic [63:0] s_pc    [NC];
  logic [31:0] s_inst  [NC];
  logic        s_wen   [NC];
  logic [4:0]  s_wdest [NC];
  logic [63:0] s_wdata [NC];
  logic        s_skip  [NC];
  logic [63:0] s_a0;

  // reference model state
  bit          m_halted;
  bit          m_trap_valid;
  logic [7:0]  m_trap_code;
  logic [63:0] m_trap_pc;
  logic [63:0] m_last_pc;
  logic [63:0] m_cycle;
  logic [63:0] m_instr;
  int          m_idle;

  // expected slot outputs
  logic [NC-1:0]    e_valid, e_skip, e_wen;
  logic [NC*64-1:0] e_pc, e_wdata;
  logic [NC*32-1:0] e_inst;
  logic [NC*8-1:0]  e_wdest;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    for (int i = 0; i < NC; i++) begin
      s_valid[i] = 1'b0; s_pc[i] = '0; s_inst[i] = '0; s_wen[i] = 1'b0;
      s_wdest[i] = '0; s_wdata[i] = '0; s_skip[i] = 1'b0;
    end
    s_a0 = '0;
  endtask

  task automatic setChan(input int i, input logic [63:0] pc, input logic [31:0] inst,
                         input logic wen, input logic [4:0] wdest, input logic [63:0] wdata);
    s_valid[i] = 1'b1; s_pc[i] = pc; s_inst[i] = inst; s_wen[i] = wen;
    s_wdest[i] = wdest; s_wdata[i] = wdata; s_skip[i] = 1'b0;
  endtask

  task automatic driveBus();
    for (int i = 0; i < NC; i++) begin
      bus.in_valid[i]           = s_valid[i];
      bus.in_pc[i*XL +: XL]     = s_pc[i];
      bus.in_inst[i*32 +: 32]   = s_inst[i];
      bus.in_wen[i]             = s_wen[i];
      bus.in_wdest[i*5 +: 5]    = s_wdest[i];
      bus.in_wdata[i*XL +: XL]  = s_wdata[i];
      bus.in_skip[i]            = s_skip[i];
    end
    bus.in_a0 = s_a0;
  endtask

  task automatic modelReset();
    m_halted = 0; m_trap_valid = 0; m_trap_code = '0; m_trap_pc = '0;
    m_last_pc = '0; m_cycle = '0; m_instr = '0; m_idle = 0;
    e_valid = '0; e_skip = '0; e_wen = '0; e_pc = '0; e_wdata = '0; e_inst = '0; e_wdest = '0;
  endtask

  // One cycle of the architectural rules: program-ordered list of surviving channels.
  task automatic modelStep();
    int  q[$];
    bit  trap;
    logic [7:0] code;
    trap = 0;
    e_valid = '0; e_skip = '0; e_wen = '0; e_pc = '0; e_wdata = '0; e_inst = '0; e_wdest = '0;
    if (m_halted) return;
    for (int i = 0; i < NC; i++) begin
      if (s_valid[i]) begin
        q.push_back(i);
        if (s_inst[i][6:0] == 7'h6b) begin
          trap = 1;
          break;
        end
      end
    end
    foreach (q[k]) begin
      int c;
      c = q[k];
      e_valid[k]          = 1'b1;
      e_pc[k*64 +: 64]    = s_pc[c];
      e_inst[k*32 +: 32]  = s_inst[c];
      e_wdata[k*64 +: 64] = s_wdata[c];
      e_wdest[k*8 +: 8]   = {3'd0, s_wdest[c]};
      e_wen[k]            = s_wen[c] && (s_wdest[c] != 5'd0);
      e_skip[k]           = s_skip[c] || (s_pc[c] == PC_START);
    end
    m_cycle = m_cycle + 64'd1;
    m_instr = m_instr + 64'(q.size());
    if (q.size() > 0) begin
      m_last_pc = s_pc[q[q.size()-1]];
      m_idle = 0;
    end else begin
      m_idle++;
    end
    if (trap) begin
      code = s_a0[7:0];
      for (int k = 0; k < q.size() - 1; k++) begin
        if (s_wen[q[k]] && s_wdest[q[k]] == 5'd10) code = s_wdata[q[k]][7:0];
      end
      m_trap_valid = 1; m_trap_code = code; m_trap_pc = s_pc[q[q.size()-1]]; m_halted = 1;
    end
`ifdef DIFFTEST_WATCHDOG_EN
    else if (m_idle == WD_TIMEOUT) begin
      m_trap_valid = 1; m_trap_code = 8'hFF; m_trap_pc = m_last_pc; m_halted = 1;
    end
`endif
  endtask

  task automatic checkOutput();
    check("cmt_valid",  bus.cmt_valid,  e_valid);
    check("cmt_pc",     bus.cmt_pc,     e_pc);
    check("cmt_inst",   bus.cmt_inst,   e_inst);
    check("cmt_skip",   bus.cmt_skip,   e_skip);
    check("cmt_wen",    bus.cmt_wen,    e_wen);
    check("cmt_wdest",  bus.cmt_wdest,  e_wdest);
    check("cmt_wdata",  bus.cmt_wdata,  e_wdata);
    check("trap_valid", bus.trap_valid, m_trap_valid);
    check("trap_code",  bus.trap_code,  m_trap_code);
    check("trap_pc",    bus.trap_pc,    m_trap_pc);
    check("cycle_cnt",  bus.cycle_cnt,  m_cycle);
    check("instr_cnt",  bus.instr_cnt,  m_instr);
    check("halted",     bus.halted,     m_halted);
  endtask

  task automatic applyStimulus();
    driveBus();
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    driveBus();
    @(posedge clock);
    modelReset();
    #1;
    checkOutput();
    reset = 1'b0;
  endtask

  task automatic randomInputs(input bit allow_trap);
    logic [4:0] dests [4];
    dests[0] = 5'd0; dests[1] = 5'd10; dests[2] = 5'd1; dests[3] = 5'd31;
    for (int i = 0; i < NC; i++) begin
      s_valid[i] = ($urandom_range(0, 3) != 0);
      s_pc[i]    = PC_START + 64'($urandom_range(0, 63) << 2);
      s_inst[i]  = $urandom;
      if (s_inst[i][6:0] == 7'h6b) s_inst[i][6:0] = 7'h13;
      if (allow_trap && ($urandom_range(0, 11) == 0)) s_inst[i][6:0] = 7'h6b;
      s_wen[i]   = $urandom_range(0, 1) == 1;
      s_wdest[i] = ($urandom_range(0, 1) == 1) ? dests[$urandom_range(0, 3)] : 5'($urandom);
      s_wdata[i] = {$urandom, $urandom};
      s_skip[i]  = ($urandom_range(0, 7) == 0);
    end
    s_a0 = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] frozen_cycle;
    clearInputs();
    driveBus();
    doReset();

    // two commits, first at PC_START, second addi x1
    clearInputs();
    setChan(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    setChan(1, 64'h8000_0004, 32'h0010_0093, 1'b1, 5'd1, 64'd1);
    applyStimulus();
    check("tp1_valid", bus.cmt_valid, 2'b11);
    check("tp1_skip",  bus.cmt_skip,  2'b01);
    check("tp1_wdest1", bus.cmt_wdest[15:8], 8'h01);
    check("tp1_instr", bus.instr_cnt, 64'd2);

    // gap on channel 0 compacts into slot 0
    clearInputs();
    setChan(1, 64'h8000_0010, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    applyStimulus();
    check("tp2_valid", bus.cmt_valid, 2'b01);
    check("tp2_pc0",   bus.cmt_pc[63:0], 64'h8000_0010);
    check("tp2_pc1",   bus.cmt_pc[127:64], 64'd0);

    // write to x0 is filtered, data passes through
    clearInputs();
    setChan(0, 64'h8000_0014, 32'h0550_0013, 1'b1, 5'd0, 64'h55);
    applyStimulus();
    check("tp3_wen",   bus.cmt_wen, 2'b00);
    check("tp3_wdata", bus.cmt_wdata[63:0], 64'h55);

    for (int n = 0; n < 60; n++) begin
      randomInputs(1'b0);
      applyStimulus();
    end

    // trap on channel 1 after channel 0 wrote x10 = 0
    clearInputs();
    setChan(0, 64'h8000_00fc, 32'h0000_0513, 1'b1, 5'd10, 64'd0);
    setChan(1, 64'h8000_0100, 32'h0000_006b, 1'b0, 5'd0, 64'd0);
    s_a0 = 64'd7;
    applyStimulus();
    check("tp4_trap_valid", bus.trap_valid, 1'b1);
    check("tp4_trap_code",  bus.trap_code,  8'h00);
    check("tp4_trap_pc",    bus.trap_pc,    64'h8000_0100);
    check("tp4_halted",     bus.halted,     1'b1);
    frozen_cycle = m_cycle;
    for (int n = 0; n < 4; n++) begin
      randomInputs(1'b1);
      applyStimulus();
    end
    check("tp4_frozen_cycle", bus.cycle_cnt, frozen_cycle);
    doReset();
    check("tp4_reset_halted", bus.halted, 1'b0);

    // trap on channel 0 drops channel 1
    clearInputs();
    setChan(0, 64'h8000_0040, 32'h0000_006b, 1'b0, 5'd0, 64'd0);
    setChan(1, 64'h8000_0044, 32'h0000_0013, 1'b1, 5'd10, 64'h99);
    s_a0 = 64'd3;
    applyStimulus();
    check("tp5_valid", bus.cmt_valid, 2'b01);
    check("tp5_code",  bus.trap_code, 8'h03);
    check("tp5_instr", bus.instr_cnt, 64'd1);

    for (int r = 0; r < 6; r++) begin
      doReset();
      for (int n = 0; n < 30; n++) begin
        randomInputs(1'b1);
        applyStimulus();
      end
    end

`ifdef DIFFTEST_WATCHDOG_EN
    doReset();
    clearInputs();
    setChan(0, 64'h8000_001c, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    applyStimulus();
    clearInputs();
    for (int n = 0; n < WD_TIMEOUT - 1; n++) applyStimulus();
    setChan(0, 64'h8000_0020, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    applyStimulus();
    check("wd_commit_wins", bus.trap_valid, 1'b0);
    clearInputs();
    for (int n = 0; n < WD_TIMEOUT - 1; n++) applyStimulus();
    check("wd_not_yet", bus.trap_valid, 1'b0);
    applyStimulus();
    check("wd_trap_valid", bus.trap_valid, 1'b1);
    check("wd_trap_code",  bus.trap_code,  8'hFF);
    check("wd_trap_pc",    bus.trap_pc,    64'h8000_0020);
    check("wd_halted",     bus.halted,     1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
